program_loader: RTL and testbench
=================================

// Module: program_loader
// PURPOSE
//   Writer side of the processor's 16x8 instruction store: receives a program as a byte stream
//   over a valid/ready handshake and writes it into an internal RAM. It verifies a trailing XOR
//   checksum, then presents the RAM to the fetch side through the same addr->data read port
//   that ROM_MODULE provides. The fetch counter and ALU keep stepping unchanged.
// PARAMETERS
//   DEPTH    15    program length in bytes; valid addresses 0..DEPTH-1 (max 16)
//   TIMEOUT  1000  consecutive stall cycles in LOAD/CHECK before ERROR (16-bit counter)
// PORTS
//   CLK       in   1  single system clock; all state changes on rising edge
//   RESET     in   1  synchronous, active-high reset
//   start     in   1  one-cycle pulse; begins a (re)load
//   in_data   in   8  program byte {opcode[7:4], data[3:0]}, then checksum byte
//   in_valid  in   1  in_data valid this cycle
//   in_ready  out  1  loader accepts a byte this cycle
//   rd_addr   in   4  fetch address (Q_mem_cnt)
//   rd_data   out  8  fetched instruction, combinational
//   loaded    out  1  program verified; fetch side may run
//   busy      out  1  state is LOAD or CHECK
//   error     out  1  checksum mismatch or timeout
//   wr_count  out  4  number of program bytes written in the current load
// BEHAVIOUR
//   - Transfer: byte accepted on a rising edge where in_valid & in_ready.
//     in_ready is decoded combinationally from state: 1 in LOAD and CHECK only.
//   - Reset (sync): state=IDLE; wr_ptr, wr_count, xor_acc and stall_cnt=0; loaded, error, busy=0.
//     RAM contents are not cleared.
//   - rd_data = (loaded && rd_addr < DEPTH) ? mem[rd_addr] : 8'h00.
//     While not loaded, the fetch side sees opcode 0 / data 0.
//   - FSM:
//     IDLE : start -> LOAD; clear wr_ptr, xor_acc and stall_cnt.
//     LOAD : each accepted byte: mem[wr_ptr]<=in_data, wr_ptr++, xor_acc^=in_data.
//            The edge accepting byte DEPTH-1 -> CHECK.
//     CHECK: accepted byte compared with the final xor_acc on the same edge.
//            Equal -> DONE; loaded=1 from the next cycle. Unequal -> ERROR; error=1 from the next cycle.
//     DONE : holds. start -> LOAD, clears loaded on the same edge.
//     ERROR: holds, error stays 1. start -> LOAD, clears error.
//   - start while in LOAD or CHECK: ignored, no restart.
//   - Timeout: stall_cnt increments on each LOAD/CHECK cycle without a transfer and clears on each
//     transfer. A cycle with stall_cnt==TIMEOUT-1 and no transfer -> ERROR on that edge.
//   - wr_count = wr_ptr, saturating at DEPTH. It holds in DONE/ERROR and clears on the LOAD entry edge.
//   - Write/read of the same address in one cycle cannot occur (loaded=0 during LOAD).
//   - RESET mid-load: abort to IDLE, loaded=0. The partially written RAM is never exposed.
//   - Width rules: xor_acc is 8 bits; wr_ptr is 4 bits and never exceeds DEPTH.
// TESTING
//   1 Reset, then read all 16 addresses -> rd_data=8'h00, loaded=0, in_ready=0.
//   2 start, stream 0F 8A 11 05 9A 5E 6E 7F 8E 91 AA B5 C5 D3 EF then BD, valid every cycle
//     -> loaded=1 one cycle after BD accepted. rd_addr 0..14 returns the bytes in order;
//     rd_addr 15 -> 00; wr_count=15.
//   3 Same stream, checksum 8'hBC -> error=1, loaded=0, rd_data=00.
//     A new start with correct data -> error=0, loaded=1.
//   4 Stream with in_valid toggling 1/0 -> identical final RAM and loaded=1.
//     in_ready=1 throughout LOAD/CHECK.
//   5 Stop after 7 bytes, in_valid=0 -> error=1 exactly TIMEOUT cycles after the last transfer.
//     start during LOAD ignored (wr_count unaffected).
//   6 RESET asserted after 10 bytes -> next edge: IDLE, busy=0, loaded=0, wr_count=0.
//     A full reload then succeeds.

Source files
------------

// File: rtl/program_loader.sv
// Program loader: receives a program byte stream over valid/ready and writes it
// into a 16x8 instruction RAM. A trailing XOR checksum byte is then verified.
// Only after a successful check does the fetch side see the RAM contents.
// Before that it reads all-zero instructions.
module program_loader #(
  parameter int DEPTH   = 15,
  parameter int TIMEOUT = 1000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       loaded,
  output logic       busy,
  output logic       error,
  output logic [3:0] wr_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [3:0]  LAST_PTR  = 4'(DEPTH - 1);
  localparam logic [4:0]  DEPTH_W   = 5'(DEPTH);
  localparam logic [15:0] STALL_MAX = 16'(TIMEOUT - 1);

  state_t      state;
  state_t      next_state;
  logic [3:0]  wr_ptr;
  logic [7:0]  xor_acc;
  logic [15:0] stall_cnt;
  logic        xfer;
  logic        wr_en;
  logic        enter_load;
  logic [7:0]  mem [0:15];

  // Byte count reported to the outside never exceeds the program length.
  function automatic logic [3:0] sat_count(input logic [3:0] ptr);
    if ({1'b0, ptr} > DEPTH_W) sat_count = DEPTH_W[3:0];
    else                       sat_count = ptr;
  endfunction

  assign busy     = (state == S_LOAD) || (state == S_CHECK);
  assign in_ready = busy;
  assign loaded   = (state == S_DONE);
  assign error    = (state == S_ERROR);
  assign xfer     = in_valid & in_ready;
  assign wr_count = sat_count(wr_ptr);

  // The RAM is exposed only once a program has been verified.
  assign rd_data = (loaded && ({1'b0, rd_addr} < DEPTH_W)) ? mem[rd_addr] : 8'h00;

  // Next-state decode: byte acceptance, checksum verdict and stall timeout.
  always_comb begin
    next_state = state;
    enter_load = 1'b0;
    wr_en      = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          next_state = S_LOAD;
          enter_load = 1'b1;
        end
      end
      S_LOAD: begin
        if (xfer) begin
          wr_en = 1'b1;
          if (wr_ptr == LAST_PTR) next_state = S_CHECK;
        end else if (stall_cnt == STALL_MAX) begin
          next_state = S_ERROR;
        end
      end
      S_CHECK: begin
        if (xfer) begin
          next_state = (in_data == xor_acc) ? S_DONE : S_ERROR;
        end else if (stall_cnt == STALL_MAX) begin
          next_state = S_ERROR;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // State register plus write pointer, running checksum and stall counter.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= S_IDLE;
      wr_ptr    <= 4'd0;
      xor_acc   <= 8'd0;
      stall_cnt <= 16'd0;
    end else begin
      state <= next_state;
      if (enter_load) begin
        wr_ptr    <= 4'd0;
        xor_acc   <= 8'd0;
        stall_cnt <= 16'd0;
      end else if (busy) begin
        if (xfer) stall_cnt <= 16'd0;
        else      stall_cnt <= stall_cnt + 16'd1;
        if (wr_en) begin
          wr_ptr  <= wr_ptr + 4'd1;
          xor_acc <= xor_acc ^ in_data;
        end
      end
    end
  end

  // Instruction RAM write port; contents survive reset.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_ptr] <= in_data;
  end

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader: directed loads of the reference program plus
// randomized programs and handshake gaps, checked against a simple model.
module tb_program_loader;

  localparam int DEPTH   = 15;
  localparam int TIMEOUT = 1000;
  localparam logic [7:0] SPEC [15] = '{8'h0F, 8'h8A, 8'h11, 8'h05, 8'h9A,
                                      8'h5E, 8'h6E, 8'h7F, 8'h8E, 8'h91,
                                      8'hAA, 8'hB5, 8'hC5, 8'hD3, 8'hEF};

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       start = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] rd_addr = 4'h0;
  logic [7:0] rd_data;
  logic       loaded;
  logic       busy;
  logic       error;
  logic [3:0] wr_count;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] tx [16];
  logic [7:0] m_mem [16];
  bit         m_loaded = 1'b0;
  bit         m_error = 1'b0;

  program_loader #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .rd_addr(rd_addr),
    .rd_data(rd_data), .loaded(loaded), .busy(busy), .error(error),
    .wr_count(wr_count)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, required finish");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_spec(input logic [7:0] csum);
    for (int i = 0; i < DEPTH; i++) tx[i] = SPEC[i];
    tx[DEPTH] = csum;
  endtask

  task automatic fill_random(input bit corrupt);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      tx[i] = 8'($urandom);
      x ^= tx[i];
    end
    tx[DEPTH] = corrupt ? (x ^ 8'($urandom_range(1, 255))) : x;
  endtask

  // Model: a complete load is kept only when the trailing byte equals the XOR of the program.
  task automatic model_commit();
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < DEPTH; i++) x ^= tx[i];
    if (x == tx[DEPTH]) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = tx[i];
      m_loaded = 1'b1;
      m_error  = 1'b0;
    end else begin
      m_loaded = 1'b0;
      m_error  = 1'b1;
    end
  endtask

  task automatic check_state(input logic [3:0] exp_wc);
    chk("loaded", loaded, m_loaded);
    chk("error", error, m_error);
    chk("busy", busy, 1'b0);
    chk("in_ready_idle", in_ready, 1'b0);
    chk("wr_count", wr_count, exp_wc);
    for (int a = 0; a < 16; a++) begin
      @(negedge CLK);
      rd_addr = 4'(a);
      #1;
      chk($sformatf("rd_data[%0d]", a), rd_data,
          (m_loaded && a < DEPTH) ? m_mem[a] : 8'h00);
    end
  endtask

  task automatic start_load();
    @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    m_loaded = 1'b0;
    m_error  = 1'b0;
    chk("busy_after_start", busy, 1'b1);
    chk("loaded_after_start", loaded, 1'b0);
    chk("error_after_start", error, 1'b0);
    chk("wr_count_after_start", wr_count, 4'd0);
  endtask

  // mode 0: valid every cycle, 1: alternating, 2: random gaps
  task automatic push_bytes(input int n, input int mode);
    int idx;
    int cyc;
    bit v;
    idx = 0;
    cyc = 0;
    while (idx < n && cyc < 400) begin
      if (mode == 0)      v = 1'b1;
      else if (mode == 1) v = (cyc % 2 == 0);
      else                v = ($urandom_range(0, 2) != 0);
      in_valid = v;
      in_data  = v ? tx[idx] : 8'($urandom);
      chk("in_ready_busy", in_ready, 1'b1);
      @(negedge CLK);
      if (v) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    chk("push_complete", idx, n);
  endtask

  task automatic run_load(input int mode);
    start_load();
    push_bytes(DEPTH + 1, mode);
    model_commit();
    check_state(4'(DEPTH));
  endtask

  initial begin
    // Test 1: reset state
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    check_state(4'd0);

    // Test 2: reference program with correct checksum
    fill_spec(8'hBD);
    run_load(0);

    // Test 3: bad checksum, then a good reload
    fill_spec(8'hBC);
    run_load(0);
    fill_spec(8'hBD);
    run_load(0);

    // Test 4: alternating valid, then random programs with random gaps
    fill_spec(8'hBD);
    run_load(1);
    for (int k = 0; k < 6; k++) begin
      fill_random(k % 3 == 2);
      run_load(2);
    end

    // Test 5: stall after 7 bytes, start during LOAD ignored, timeout
    fill_spec(8'hBD);
    start_load();
    push_bytes(7, 0);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    chk("ignored_start_wr_count", wr_count, 4'd7);
    chk("ignored_start_busy", busy, 1'b1);
    repeat (TIMEOUT - 2) @(negedge CLK);
    chk("error_before_timeout", error, 1'b0);
    chk("busy_before_timeout", busy, 1'b1);
    @(negedge CLK);
    chk("error_at_timeout", error, 1'b1);
    m_loaded = 1'b0;
    m_error  = 1'b1;
    check_state(4'd7);

    // Test 6: reset mid-load, then a full reload
    fill_random(1'b0);
    start_load();
    push_bytes(10, 0);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    m_loaded = 1'b0;
    m_error  = 1'b0;
    check_state(4'd0);
    fill_spec(8'hBD);
    run_load(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
